// File: rtl/par_call_pkg.sv
// Shared types and helpers for the par_call_reduce fan-out/fan-in block.
package par_call_pkg;

    // Top-level sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        RUN,
        FINISH,
        DRAIN
    } state_t;

    // Cycles after a start pulse during which a unit's done output is stale.
    localparam int GUARD = 2;

    // Widest operand the product helper supports.
    localparam int MAX_W = 64;

    // Ceiling log2 with a floor of one bit, for index and counter widths.
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

    // Full-width product; callers keep the low WIDTH bits.
    function automatic logic [MAX_W-1:0] mulw(input logic [MAX_W-1:0] r,
                                              input logic [MAX_W-1:0] w);
        return r * w;
    endfunction

endpackage

// File: rtl/par_call_reduce_call_slot.sv
// One execution slot: wraps a g instance and tracks which call it is running,
// masking the stale done level for a short guard window after each start.
module call_slot
    import par_call_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IDX_W     = 2,
    parameter int G_LATENCY = 3,
    parameter int G_VAR_LAT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             issue,
    input  logic [WIDTH-1:0] issue_a,
    input  logic [WIDTH-1:0] issue_b,
    input  logic [IDX_W-1:0] issue_idx,
    input  logic             release_unit,
    output logic             free,
    output logic             pending,
    output logic             busy,
    output logic [IDX_W-1:0] slot_idx,
    output logic [WIDTH-1:0] result
);

    logic             start_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       guard_cnt;
    logic             g_done;

    g #(
        .WIDTH  (WIDTH),
        .LATENCY(G_LATENCY),
        .VAR_LAT(G_VAR_LAT)
    ) u_g (
        .clk   (clk),
        .reset (reset),
        .start (start_q),
        .a     (a_q),
        .b     (b_q),
        .done  (g_done),
        .result(result)
    );

    // Slot bookkeeping: one-cycle start pulse on issue, guard countdown, busy until the result is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            start_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            slot_idx  <= '0;
            guard_cnt <= '0;
        end else begin
            start_q <= 1'b0;
            if (guard_cnt != 2'd0) begin
                guard_cnt <= guard_cnt - 2'd1;
            end
            if (clear) begin
                busy <= 1'b0;
            end else if (issue) begin
                busy      <= 1'b1;
                start_q   <= 1'b1;
                a_q       <= issue_a;
                b_q       <= issue_b;
                slot_idx  <= issue_idx;
                guard_cnt <= 2'(GUARD);
            end else if (release_unit) begin
                busy <= 1'b0;
            end
        end
    end

    assign free    = !busy;
    assign pending = busy && (guard_cnt == 2'd0) && g_done;

endmodule

// File: rtl/par_call_reduce_g.sv
// Child compute unit g: multiplies a by b after a fixed (optionally
// operand-dependent) latency. done idles high and result holds while idle.
module g #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3,
    parameter int VAR_LAT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic             busy;
    logic [7:0]       cnt;
    logic [7:0]       extra;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Optional extra latency taken from the low bits of b, so different calls can finish out of order.
    always_comb begin
        extra = 8'd0;
        if (VAR_LAT != 0) begin
            extra = {6'd0, b[1:0]};
        end
    end

    // Accept a start while idle, count down, then publish the product and go idle again.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            cnt    <= 8'd0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
        end else if (!busy) begin
            if (start) begin
                busy <= 1'b1;
                done <= 1'b0;
                cnt  <= 8'(LATENCY - 1) + extra;
                a_q  <= a;
                b_q  <= b;
            end
        end else if (cnt == 8'd0) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= a_q * b_q;
        end else begin
            cnt <= cnt - 8'd1;
        end
    end

endmodule

// File: rtl/par_call_reduce.sv
// Fan-out/fan-in call block: latches N_CALLS operand pairs and weights,
// time-shares them over N_UNITS g instances and returns the weighted sum.
module par_call_reduce
    import par_call_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int N_CALLS   = 4,
    parameter int N_UNITS   = 2,
    parameter int WEIGHT_W  = 8,
    parameter int TIMEOUT   = 0,
    parameter int G_LATENCY = 3,
    parameter int G_VAR_LAT = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [N_CALLS*WIDTH-1:0]    x,
    input  logic [N_CALLS*WIDTH-1:0]    y,
    input  logic [N_CALLS*WEIGHT_W-1:0] w,
    output logic [WIDTH-1:0]            result,
    output logic                        done,
    output logic                        error
);

    localparam int IDX_W = clog2(N_CALLS);
    localparam int CNT_W = clog2(N_CALLS + 1);

    state_t state;
    state_t state_next;

    logic [N_CALLS*WIDTH-1:0]    x_q;
    logic [N_CALLS*WIDTH-1:0]    y_q;
    logic [N_CALLS*WEIGHT_W-1:0] w_q;
    logic [CNT_W-1:0]            next_call;
    logic [CNT_W-1:0]            acc_count;
    logic [WIDTH-1:0]            acc;
    logic [WIDTH-1:0]            acc_next;
    logic [31:0]                 wd_cnt;

    logic [N_UNITS-1:0] unit_free;
    logic [N_UNITS-1:0] unit_pending;
    logic [N_UNITS-1:0] unit_busy;
    logic [N_UNITS-1:0] unit_issue;
    logic [N_UNITS-1:0] unit_release;
    logic [IDX_W-1:0]   unit_idx    [N_UNITS];
    logic [WIDTH-1:0]   unit_result [N_UNITS];

    logic             issue_hit;
    logic             acc_hit;
    logic             run_complete;
    logic             timeout_hit;
    logic             drain_ok;
    logic [IDX_W-1:0] issue_idx;
    logic [WIDTH-1:0] issue_a;
    logic [WIDTH-1:0] issue_b;
    logic [WIDTH-1:0] sel_r;
    logic [WEIGHT_W-1:0] sel_w;

    for (genvar u = 0; u < N_UNITS; u++) begin : g_unit
        call_slot #(
            .WIDTH    (WIDTH),
            .IDX_W    (IDX_W),
            .G_LATENCY(G_LATENCY),
            .G_VAR_LAT(G_VAR_LAT)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .clear       (state == LATCH),
            .issue       (unit_issue[u]),
            .issue_a     (issue_a),
            .issue_b     (issue_b),
            .issue_idx   (issue_idx),
            .release_unit(unit_release[u]),
            .free        (unit_free[u]),
            .pending     (unit_pending[u]),
            .busy        (unit_busy[u]),
            .slot_idx    (unit_idx[u]),
            .result      (unit_result[u])
        );
    end

    assign issue_idx    = next_call[IDX_W-1:0];
    assign issue_a      = x_q[issue_idx*WIDTH +: WIDTH];
    assign issue_b      = y_q[issue_idx*WIDTH +: WIDTH];
    assign run_complete = (acc_count == CNT_W'(N_CALLS));
    assign timeout_hit  = (TIMEOUT > 0) && (state == RUN) && !run_complete &&
                          (wd_cnt == 32'(TIMEOUT - 1));
    assign drain_ok     = &(~unit_busy | unit_pending);

    // Issue the next call to the lowest-index free unit, at most one per cycle.
    always_comb begin
        unit_issue = '0;
        issue_hit  = 1'b0;
        if (state == RUN && !timeout_hit && next_call < CNT_W'(N_CALLS)) begin
            for (int u = 0; u < N_UNITS; u++) begin
                if (!issue_hit && unit_free[u]) begin
                    unit_issue[u] = 1'b1;
                    issue_hit     = 1'b1;
                end
            end
        end
    end

    // Fold in the lowest-index completed unit's weighted result, at most one per cycle.
    always_comb begin
        unit_release = '0;
        acc_hit      = 1'b0;
        sel_r        = '0;
        sel_w        = '0;
        if (state == RUN && !timeout_hit) begin
            for (int u = 0; u < N_UNITS; u++) begin
                if (!acc_hit && unit_pending[u]) begin
                    unit_release[u] = 1'b1;
                    acc_hit         = 1'b1;
                    sel_r           = unit_result[u];
                    sel_w           = w_q[unit_idx[u]*WEIGHT_W +: WEIGHT_W];
                end
            end
        end
        acc_next = acc + WIDTH'(mulw(MAX_W'(sel_r), MAX_W'(sel_w)));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; completion wins over a same-cycle watchdog expiry.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LATCH;
            LATCH:   state_next = RUN;
            RUN: begin
                if (run_complete) begin
                    state_next = FINISH;
                end else if (timeout_hit) begin
                    state_next = DRAIN;
                end
            end
            FINISH:  state_next = IDLE;
            DRAIN:   if (drain_ok) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and handshake outputs driven by the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            result    <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            next_call <= '0;
            acc_count <= '0;
            acc       <= '0;
            wd_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        done  <= 1'b0;
                        error <= 1'b0;
                    end else begin
                        done <= 1'b1;
                    end
                end
                LATCH: begin
                    x_q       <= x;
                    y_q       <= y;
                    w_q       <= w;
                    next_call <= '0;
                    acc_count <= '0;
                    acc       <= '0;
                    wd_cnt    <= '0;
                end
                RUN: begin
                    wd_cnt <= wd_cnt + 32'd1;
                    if (issue_hit) begin
                        next_call <= next_call + 1'b1;
                    end
                    if (acc_hit) begin
                        acc       <= acc_next;
                        acc_count <= acc_count + 1'b1;
                    end
                    if (timeout_hit) begin
                        result <= acc;
                        error  <= 1'b1;
                    end
                end
                FINISH: begin
                    result <= acc;
                    done   <= 1'b1;
                end
                DRAIN: begin
                    if (drain_ok) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_par_call_reduce.sv
// Self-checking bench for par_call_reduce: four configurations share one
// clock and reset; expected results go into a scoreboard at start and are
// compared when the matching done rises.
module tb_par_call_reduce;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  start_v;
    logic [3:0]  done_v;
    logic [3:0]  error_v;
    logic [31:0] result_v [4];
    logic [95:0] x_v [4];
    logic [95:0] y_v [4];
    logic [23:0] w_v [4];
    logic [7:0]  result_c;
    logic [3:0]  prev_done = 4'b0000;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t sb_q [$];
    exp_t mon_e;

    always #5 clk = ~clk;

    // A: three units, operand-dependent child latency.
    par_call_reduce #(.WIDTH(32), .N_CALLS(3), .N_UNITS(3), .WEIGHT_W(8),
                      .TIMEOUT(0), .G_LATENCY(3), .G_VAR_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .x(x_v[0]), .y(y_v[0]),
        .w(w_v[0]), .result(result_v[0]), .done(done_v[0]), .error(error_v[0]));

    // B: single unit, calls fully serialised.
    par_call_reduce #(.WIDTH(32), .N_CALLS(3), .N_UNITS(1), .WEIGHT_W(8),
                      .TIMEOUT(0), .G_LATENCY(3), .G_VAR_LAT(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .x(x_v[1]), .y(y_v[1]),
        .w(w_v[1]), .result(result_v[1]), .done(done_v[1]), .error(error_v[1]));

    // C: 8-bit datapath for wrap-around.
    par_call_reduce #(.WIDTH(8), .N_CALLS(1), .N_UNITS(1), .WEIGHT_W(8),
                      .TIMEOUT(0), .G_LATENCY(3), .G_VAR_LAT(0)) dut_c (
        .clk(clk), .reset(reset), .start(start_v[2]), .x(x_v[2][7:0]), .y(y_v[2][7:0]),
        .w(w_v[2][7:0]), .result(result_c), .done(done_v[2]), .error(error_v[2]));

    assign result_v[2] = {24'd0, result_c};

    // E: watchdog shorter than the child latency.
    par_call_reduce #(.WIDTH(32), .N_CALLS(3), .N_UNITS(2), .WEIGHT_W(8),
                      .TIMEOUT(5), .G_LATENCY(20), .G_VAR_LAT(0)) dut_e (
        .clk(clk), .reset(reset), .start(start_v[3]), .x(x_v[3]), .y(y_v[3]),
        .w(w_v[3]), .result(result_v[3]), .done(done_v[3]), .error(error_v[3]));

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] ref_sum(input logic [95:0] xs, input logic [95:0] ys,
                                            input logic [23:0] ws, input int n, input int width);
        logic [63:0] total;
        total = 64'd0;
        for (int i = 0; i < n; i++) begin
            total = total + 64'(ws[i*8 +: 8]) * 64'(xs[i*32 +: 32]) * 64'(ys[i*32 +: 32]);
        end
        if (width < 32) begin
            total = total & ((64'd1 << width) - 64'd1);
        end
        return total[31:0];
    endfunction

    task automatic apply_stimulus(input int id, input logic [95:0] xs, input logic [95:0] ys,
                                  input logic [23:0] ws, input int n, input int width,
                                  input bit expect_timeout);
        exp_t e;
        e.id  = id;
        e.res = expect_timeout ? 32'd0 : ref_sum(xs, ys, ws, n, width);
        e.err = expect_timeout;
        @(posedge clk);
        #1;
        x_v[id]     = xs;
        y_v[id]     = ys;
        w_v[id]     = ws;
        start_v[id] = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start_v[id] = 1'b0;
    endtask

    task automatic wait_results(input int budget, output int cycles);
        cycles = 0;
        while (sb_q.size() > 0 && cycles < budget) begin
            @(posedge clk);
            cycles++;
        end
        if (sb_q.size() > 0) begin
            check_output("result_wait_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic check_reset_state(input string when_tag);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("%s_done%0d", when_tag, i), {31'd0, done_v[i]}, 32'd0);
            check_output($sformatf("%s_result%0d", when_tag, i), result_v[i], 32'd0);
            check_output($sformatf("%s_error%0d", when_tag, i), {31'd0, error_v[i]}, 32'd0);
        end
    endtask

    // Scoreboard monitor: pop and compare on each rising done of the expected unit.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_v[i] && !prev_done[i] && sb_q.size() > 0) begin
                if (sb_q[0].id == i) begin
                    mon_e = sb_q.pop_front();
                    check_output($sformatf("dut%0d_result", i), result_v[i], mon_e.res);
                    check_output($sformatf("dut%0d_error", i), {31'd0, error_v[i]},
                                 {31'd0, mon_e.err});
                end
            end
            prev_done[i] = done_v[i];
        end
    end

    initial begin
        int cyc;
        logic [95:0] rx;
        logic [95:0] ry;
        logic [23:0] rw;

        reset   = 1'b1;
        start_v = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            x_v[i] = '0;
            y_v[i] = '0;
            w_v[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // Basic weighted sum: 2*5*1 + 3*6*2 + 4*7*1 = 74.
        apply_stimulus(0, {32'd4, 32'd3, 32'd2}, {32'd7, 32'd6, 32'd5}, {8'd1, 8'd2, 8'd1}, 3, 32, 1'b0);
        wait_results(200, cyc);
        check_output("dut0_done_high", {31'd0, done_v[0]}, 32'd1);

        // Calls 0 and 1 complete in the same cycle: 10 + 24 + 72 = 106.
        apply_stimulus(0, {32'd4, 32'd3, 32'd2}, {32'd6, 32'd4, 32'd5}, {8'd3, 8'd2, 8'd1}, 3, 32, 1'b0);
        wait_results(200, cyc);

        // Same call set through a single unit.
        apply_stimulus(1, {32'd4, 32'd3, 32'd2}, {32'd7, 32'd6, 32'd5}, {8'd1, 8'd2, 8'd1}, 3, 32, 1'b0);
        wait_results(200, cyc);

        // 8-bit wrap: 16*16*3 = 768 -> 0, then 15*17*2 = 510 -> 254.
        apply_stimulus(2, 96'd16, 96'd16, 24'd3, 1, 8, 1'b0);
        wait_results(200, cyc);
        apply_stimulus(2, 96'd15, 96'd17, 24'd2, 1, 8, 1'b0);
        wait_results(200, cyc);

        // Random transactions on the multi-unit and single-unit configurations.
        for (int k = 0; k < 4; k++) begin
            rx = {$urandom, $urandom, $urandom};
            ry = {$urandom, $urandom, $urandom};
            rw = 24'($urandom);
            apply_stimulus(k % 2, rx, ry, rw, 3, 32, 1'b0);
            wait_results(200, cyc);
        end

        // Watchdog abort: partial sum 0, error set, done only after the children finish.
        apply_stimulus(3, {32'd4, 32'd3, 32'd2}, {32'd7, 32'd6, 32'd5}, {8'd1, 8'd2, 8'd1}, 3, 32, 1'b1);
        wait_results(200, cyc);
        check_output("dut3_drain_waits", {31'd0, (cyc >= 20)}, 32'd1);

        // Reset in the middle of a run on A, then a clean transaction.
        @(posedge clk);
        #1;
        x_v[0]     = {32'd9, 32'd8, 32'd7};
        y_v[0]     = {32'd3, 32'd2, 32'd1};
        w_v[0]     = {8'd5, 8'd5, 8'd5};
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("midrun_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        apply_stimulus(0, {32'd4, 32'd3, 32'd2}, {32'd7, 32'd6, 32'd5}, {8'd1, 8'd2, 8'd1}, 3, 32, 1'b0);
        wait_results(200, cyc);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/par_call_reduce.md
Name: par_call_reduce

Overview:
- Generalised fan-out/fan-in call block: latches N_CALLS operand pairs and per-call weights on start.
- Dispatches the calls onto N_UNITS instances of the child compute module g, waits for completion, and returns the weighted sum of the child results.
- Sits between a sequencer issuing start/done transactions and a pool of g instances; N_UNITS < N_CALLS time-shares the units.
- Adds an optional watchdog timeout with an error flag.

Parameters:
- WIDTH, 32, operand/result width (also g's width).
- N_CALLS, 4, number of child calls per transaction (>=1).
- N_UNITS, 2, number of g instances (1..N_CALLS).
- WEIGHT_W, 8, unsigned weight width per call.
- TIMEOUT, 0, max RUN cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a transaction; sampled only in IDLE.
- x  in  N_CALLS*WIDTH  operand a of call i at bits [i*WIDTH +: WIDTH].
- y  in  N_CALLS*WIDTH  operand b of call i.
- w  in  N_CALLS*WEIGHT_W  weight of call i.
- result  out  WIDTH  sum over i of w_i*r_i, modulo 2^WIDTH.
- done  out  1  high when idle/complete, low while busy.
- error  out  1  high with done when the transaction was aborted by timeout.

Behaviour:
- Reset: result=0, done=0, error=0, state=IDLE, all unit starts=0, accumulator=0, operand/weight latches=0. Reset mid-transaction abandons it; g instances share reset.
- IDLE:
  - start=1 -> LATCH, done<=0, error<=0.
  - start=0 -> done<=1.
- LATCH (1 cycle): register x, y, w; next_call=0; acc=0; all units free -> RUN.
- RUN issue:
  - At most one issue per cycle.
  - If next_call<N_CALLS and some unit is free, pick the lowest-index free unit.
  - Drive its a/b from call next_call and pulse its start for exactly 1 cycle.
  - Record the call index in that unit's slot; next_call++.
- RUN guard: a unit ignores its done for 2 cycles after its start pulse, because stale idle-high done is still visible. After the guard, done=1 marks the unit complete-pending.
- RUN accumulate:
  - At most one accumulation per cycle, lowest-index complete-pending unit first.
  - acc <= acc + w[slot]*r_unit, product and sum truncated to WIDTH.
  - The unit becomes free in the same cycle; g holds result while idle, so pending results remain valid.
  - Issue and accumulate may occur in the same cycle. A unit freed by accumulation is not reissued until the next cycle.
- RUN exit: all N_CALLS issued and accumulated -> FINISH.
- FINISH (1 cycle): result<=acc, done<=1 -> IDLE.
- Watchdog (TIMEOUT>0):
  - A cycle counter runs in RUN.
  - On reaching TIMEOUT: result<=acc (partial), error<=1, go to DRAIN.
  - DRAIN issues nothing and waits until every busy unit (post-guard) shows done=1, then done<=1 -> IDLE.
- Latency: start sampled at cycle 0; done low from cycle 1. With N_UNITS=N_CALLS and child latency L, done rises at roughly N_CALLS+L+N_CALLS+3 cycles.
- start while busy is ignored; start held high re-triggers immediately on return to IDLE.
- N_UNITS=1 serialises calls in index order.

Decomposition:
- Package par_call_pkg holds:
  - state enum IDLE/LATCH/RUN/FINISH/DRAIN;
  - localparam GUARD=2;
  - function clog2 for the slot index width (sized for N_CALLS);
  - function mulw(r, w) returning the WIDTH-truncated product.
- Sub-module call_slot, instantiated once per unit:
  - holds the busy/guard/pending flags, slot index and start pulse;
  - wraps one g instance;
  - exposes free, pending and result.

Test Plan:
- Single transaction, N_CALLS=3, N_UNITS=3, child stub g=a*b latency 3, x=(2,3,4), y=(5,6,7), w=(1,2,1) -> result=10+36+28=74, done high, error=0.
- N_UNITS=1, same inputs -> result=74; start pulses strictly serialised; at most one unit busy.
- Overflow, WIDTH=8, x=(16), y=(16), w=(3) -> result=(256*3) mod 256=0.
- Simultaneous completion: two units finish in the same cycle -> accumulated on consecutive cycles lowest-first; result matches reference sum.
- TIMEOUT=5 with child latency 20 -> error=1, result=partial acc (0). done rises only after all busy units report done.
- Reset asserted mid-RUN -> next cycle done=0, result=0, no unit start pulse. A new start after release gives the correct result.
